// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the 7-segment scan block.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0    = 7'b1000000;
  localparam seg7_t SEG_1    = 7'b1111001;
  localparam seg7_t SEG_2    = 7'b0100100;
  localparam seg7_t SEG_3    = 7'b0110000;
  localparam seg7_t SEG_4    = 7'b0011001;
  localparam seg7_t SEG_5    = 7'b0010010;
  localparam seg7_t SEG_6    = 7'b0000010;
  localparam seg7_t SEG_7    = 7'b1111000;
  localparam seg7_t SEG_8    = 7'b0000000;
  localparam seg7_t SEG_9    = 7'b0010000;
  localparam seg7_t SEG_DASH = 7'b0111111;
  localparam seg7_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  // Table lookup; 10..15 fall through to the dash pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode multiplexed display driver (HH.MM) with per-slot
// anti-ghost blanking, frame-coherent snapshot, leading-zero blanking and a
// blinking colon on the idx 2 decimal point. All outputs are registered.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned BLANK_CYC   = 250,
  parameter int unsigned BLINK_DIV   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hora_d,
  input  logic [3:0] hora_u,
  input  logic [3:0] min_d,
  input  logic [3:0] min_u,
  input  logic       blank_lz,
  output logic [3:0] an,
  output seg7_t      seg,
  output logic       dp
);

  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BcntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CntW-1:0]  CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0]  BlankLim = CntW'(BLANK_CYC);
  localparam logic [BcntW-1:0] BcntMax  = BcntW'(BLINK_DIV - 1);

  logic [CntW-1:0]  cnt_q;
  logic [BcntW-1:0] bcnt_q;
  digit_idx_t       idx_q;
  logic             blink_q;
  // Snapshot indexed like idx: [0]=min_u, [1]=min_d, [2]=hora_u, [3]=hora_d.
  logic [3:0][3:0]  snap_q;

  logic       tick;
  logic       blanked;
  logic [3:0] cur_digit;
  seg7_t      seg_d;
  logic [3:0] an_d;
  logic       dp_d;

  // Slot tick, current digit select and visibility decision.
  always_comb begin
    tick      = (cnt_q == CntMax);
    cur_digit = snap_q[idx_q];
    blanked   = (cnt_q < BlankLim) ||
                ((idx_q == 2'd3) && blank_lz && (snap_q[3] == 4'd0));
    an_d      = blanked ? 4'b1111 : ~(4'b0001 << idx_q);
    dp_d      = ~((idx_q == 2'd2) && blink_q && !blanked);
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (seg_d)
  );

  // Refresh counter and digit index; index wraps naturally at 2 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Free-running colon blink divider, independent of the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (bcnt_q == BcntMax) begin
      bcnt_q  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bcnt_q <= bcnt_q + 1'b1;
    end
  end

  // Capture all four digits together as the scan wraps to idx 0 (no tearing).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (tick && (idx_q == 2'd3)) begin
      snap_q <= {hora_d, hora_u, min_d, min_u};
    end
  end

  // Output registers; seg is driven even while the anode is blanked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
